// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared FSM encoding and sentinel constants for the ccff chain loader.
package ccff_loader_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SENTINEL, ST_SHIFT, ST_FINISH} state_t;
    localparam logic [7:0] SENTINEL_PATTERN = 8'hA5;
    localparam int SENTINEL_LEN = 8;
endpackage

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer: buffers stream words and hands out one bit per shift, LSB first.
module ccff_word_serializer #(
    parameter int WORD_W = 8,
    parameter int CW = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              active_i,
    input  logic [CW-1:0]     rem_i,
    input  logic              in_valid_i,
    input  logic [WORD_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              bit_valid_o,
    output logic              bit_o
);
    localparam int BW = $clog2(WORD_W + 1);
    logic [WORD_W-1:0] data_q, data_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic has, take;
    always_comb begin
        has = cnt_q != '0;
        in_ready_o = active_i && (32'(rem_i) > 32'(cnt_q)) && (cnt_q <= BW'(1));
        take = in_valid_i && in_ready_o;
        bit_valid_o = active_i && (has || take);
        // an empty buffer passes bit 0 of the incoming word straight through
        bit_o = has ? data_q[0] : in_data_i[0];
        data_d = data_q;
        cnt_d = cnt_q;
        if (bit_valid_o) begin
            data_d = take ? (has ? in_data_i : in_data_i >> 1) : data_q >> 1;
            cnt_d = take ? (has ? BW'(WORD_W) : BW'(WORD_W - 1)) : cnt_q - 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            data_q <= '0;
            cnt_q <= '0;
        end else begin
            data_q <= data_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes configuration words onto a ccff chain with a gated shift clock.
// Define CCFF_LOADER_SENTINEL_EN to prepend an A5 sentinel and check it at ccff_tail.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 2,
    parameter int WORD_W = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_clk_en,
    output logic              config_enable,
    output logic              busy,
    output logic              done,
    output logic              error
);
`ifdef CCFF_LOADER_SENTINEL_EN
    localparam int N = CHAIN_LEN + SENTINEL_LEN;
    localparam state_t FIRST = ST_SENTINEL;
`else
    localparam int N = CHAIN_LEN;
    localparam state_t FIRST = ST_SHIFT;
`endif
    localparam int SW = $clog2(N + 1);
    state_t state_q, state_d;
    logic [SW-1:0] s_q, s_d, rem;
    logic head_q, shift, ser_valid, ser_bit;
    assign rem = SW'(N) - s_q;
    ccff_word_serializer #(.WORD_W(WORD_W), .CW(SW)) u_ser (
        .clk_i(prog_clk),
        .rst_i(pReset),
        .clr_i(state_q == ST_IDLE),
        .active_i(state_q == ST_SHIFT),
        .rem_i(rem),
        .in_valid_i(in_valid),
        .in_data_i(in_data),
        .in_ready_o(in_ready),
        .bit_valid_o(ser_valid),
        .bit_o(ser_bit)
    );
    always_comb begin
        state_d = state_q;
        s_d = s_q;
        shift = 1'b0;
        ccff_head = head_q;
        done = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = FIRST;
                s_d = '0;
            end
`ifdef CCFF_LOADER_SENTINEL_EN
            ST_SENTINEL: begin
                shift = 1'b1;
                ccff_head = SENTINEL_PATTERN[s_q[2:0]];
                s_d = s_q + 1'b1;
                state_d = (s_q == SW'(SENTINEL_LEN - 1)) ? ST_SHIFT : ST_SENTINEL;
            end
`endif
            ST_SHIFT: if (ser_valid) begin
                shift = 1'b1;
                ccff_head = ser_bit;
                s_d = s_q + 1'b1;
                state_d = (s_q == SW'(N - 1)) ? ST_FINISH : ST_SHIFT;
            end
            ST_FINISH: begin
                done = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    assign ccff_clk_en = shift;
    assign busy = state_q != ST_IDLE;
    assign config_enable = busy;
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q <= ST_IDLE;
            s_q <= '0;
            head_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q <= s_d;
            head_q <= ccff_head;
        end
    end
`ifdef CCFF_LOADER_SENTINEL_EN
    // sentinel bit t reaches the tail after shift t+CHAIN_LEN-1; compare it one cycle later
    logic chk_q, exp_q, flag_q;
    int t;
    always_comb t = int'(s_q) - (CHAIN_LEN - 1);
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            chk_q <= 1'b0;
            exp_q <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            chk_q <= shift && (t >= 0) && (t < SENTINEL_LEN);
            exp_q <= SENTINEL_PATTERN[t[2:0]];
            flag_q <= (state_q == ST_IDLE && start) ? 1'b0 : flag_q | (chk_q & (ccff_tail != exp_q));
        end
    end
    assign error = flag_q && (state_q == ST_FINISH || state_q == ST_IDLE);
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign error = 1'b0;
`endif
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: scoreboard bench for a 20-flop chain fed 8-bit words; follows the sentinel macro.
module tb_ccff_chain_loader;
`ifdef CCFF_LOADER_SENTINEL_EN
    localparam int SEN = 8;
    localparam bit SEN_ON = 1'b1;
`else
    localparam int SEN = 0;
    localparam bit SEN_ON = 1'b0;
`endif
    localparam int CL = 20;
    localparam int N = CL + SEN;

    typedef struct {
        logic [CL-1:0] chain;
        logic err;
        int cyc;
        int en;
        int words;
    } exp_t;

    logic clk = 1'b0;
    logic pReset, start, in_valid, in_ready, ccff_head, ccff_tail, ccff_clk_en;
    logic config_enable, busy, done, error, stuck;
    logic [7:0] in_data;
    logic [CL-1:0] chain = '0;
    exp_t sb[$];
    exp_t e;
    int n_chk = 0, n_err = 0;
    int cyc = 0, en = 0, words = 0;
    int n, spin;

    always #5 clk = ~clk;

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(8)) dut (
        .prog_clk(clk),
        .pReset(pReset),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .ccff_head(ccff_head),
        .ccff_tail(ccff_tail),
        .ccff_clk_en(ccff_clk_en),
        .config_enable(config_enable),
        .busy(busy),
        .done(done),
        .error(error)
    );

    // behavioural chain: chain[CL-1] is next to the head, chain[0] is the tail flop
    always @(posedge clk) if (ccff_clk_en) chain <= {ccff_head, chain[CL-1:1]};
    assign ccff_tail = stuck ? 1'b0 : chain[0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_head"}, ccff_head, 0);
        chk({tag, "_clk_en"}, ccff_clk_en, 0);
        chk({tag, "_cfg_en"}, config_enable, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    always @(negedge clk) begin
        if (pReset || !busy) begin
            cyc = 0;
            en = 0;
            words = 0;
        end else begin
            cyc++;
            if (ccff_clk_en) en++;
            if (in_valid && in_ready) words++;
            if (done) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected no load pending at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("chain", 32'(chain), 32'(e.chain));
                    chk("error", error, e.err);
                    chk("done_cycle", cyc, e.cyc);
                    chk("clk_en_cycles", en, e.en);
                    chk("words", words, e.words);
                end
            end
        end
    end

    task automatic load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                        input int gap1, input bit repulse, input logic [CL-1:0] exp_chain,
                        input logic exp_err);
        logic [7:0] w[3];
        int g, sp;
        w = '{w0, w1, w2};
        sb.push_back('{exp_chain, exp_err, N + 1 + gap1, N, 3});
        in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("err_clr", error, 0);
        chk("busy_set", busy, 1);
        chk("cfg_en_set", config_enable, 1);
        for (int i = 0; i < 3; i++) begin
            if (i == 1 && gap1 > 0) begin
                in_valid = 1'b0;
                g = 0;
                sp = 0;
                while (g < gap1 && sp < 200) begin
                    @(negedge clk);
                    sp++;
                    if (in_ready && !ccff_clk_en) g++;
                end
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data = w[i];
            sp = 0;
            do begin
                @(negedge clk);
                start = 1'b0;
                sp++;
            end while (!in_ready && sp < 200);
            @(posedge clk);
            #1 start = repulse && i == 0;
        end
        in_valid = 1'b0;
        sp = 0;
        while (sb.size() != 0 && sp < 300) begin
            @(negedge clk);
            start = 1'b0;
            sp++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL done_timeout: got no done expected done within bound at %0t", $time);
            sb.delete();
        end
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_cfg_en", config_enable, 0);
        chk("idle_error_held", error, exp_err);
        chk("idle_clk_en", ccff_clk_en, 0);
    endtask

    initial begin
        pReset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        stuck = 1'b0;
        repeat (3) @(posedge clk);
        #1 pReset = 1'b0;
        @(negedge clk);
        check_idle("reset");
        load(8'hFF, 8'h00, 8'hF3, 0, 1'b1, 20'h300FF, 1'b0);
        load(8'hA5, 8'h3C, 8'h96, 3, 1'b0, 20'h63CA5, 1'b0);
        stuck = 1'b1;
        load(8'h12, 8'h34, 8'h56, 0, 1'b0, 20'h63412, SEN_ON);
        stuck = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h5A;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("abort_err_clr", error, 0);
        n = 0;
        spin = 0;
        while (n < 5 && spin < 100) begin
            @(negedge clk);
            spin++;
            if (ccff_clk_en) n++;
        end
        chk("abort_shifts", n, 5);
        pReset = 1'b1;
        @(posedge clk);
        #1 pReset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("abort");
        load(8'h81, 8'h42, 8'hC3, 0, 1'b0, 20'h34281, 1'b0);
        repeat (3) @(negedge clk);
        chk("no_stray_load", busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
